uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_receiver.sv | 115 +++++++++++
 tb/tb_uart_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state encoding and bit-timing helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_INDEX_WIDTH = $clog2(DATA_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    function automatic int symbolEdgeTime(int clockFreq, int baudRate);
        return clockFreq / baudRate;
    endfunction

    function automatic int sampleTime(int clockFreq, int baudRate);
        return symbolEdgeTime(clockFreq, baudRate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for asynchronous inputs with a configurable reset value.
module uart_sync2 #(
    parameter int Width = 1,
    parameter logic [Width-1:0] ResetValue = '1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [Width-1:0] raw,
    output logic [Width-1:0] synced
);

    logic [Width-1:0] meta;

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            meta   <= ResetValue;
            synced <= ResetValue;
        end else begin
            meta   <= raw;
            synced <= meta;
        end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with one-entry ready/valid output, framing and overrun pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data bit 7 and the stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    output logic       FramingError,
    output logic       Overrun,
    output logic       ParityError
);

    localparam int SymbolEdgeTime = symbolEdgeTime(ClockFreq, BaudRate);
    localparam int SampleTime     = sampleTime(ClockFreq, BaudRate);
    localparam int CounterWidth   = $clog2(SymbolEdgeTime);
    localparam logic [CounterWidth-1:0] SampleLast = CounterWidth'(SampleTime - 1);
    localparam logic [CounterWidth-1:0] SymbolLast = CounterWidth'(SymbolEdgeTime - 1);
    localparam logic [BIT_INDEX_WIDTH-1:0] LastBit = BIT_INDEX_WIDTH'(DATA_BITS - 1);

    logic                       rx;
    logic [2:0]                 state;
    logic [CounterWidth-1:0]    counter;
    logic [BIT_INDEX_WIDTH-1:0] bitIndex;
    logic [DATA_BITS-1:0]       shiftReg;
    logic                       parityBad;

    uart_sync2 #(.Width(1), .ResetValue(1'b1)) rxSync (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (SIn),
        .synced(rx)
    );

`ifdef UART_RX_PARITY_EN
    logic parityBit;
    assign parityBad = ^{shiftReg, parityBit};
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) parityBit <= 1'b0;
        else if (state == ST_PARITY && counter == SymbolLast) parityBit <= rx;
`else
    assign parityBad = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state        <= ST_IDLE;
            counter      <= '0;
            bitIndex     <= '0;
            shiftReg     <= '0;
            DataOut      <= '0;
            DataOutValid <= 1'b0;
            FramingError <= 1'b0;
            Overrun      <= 1'b0;
            ParityError  <= 1'b0;
        end else begin
            FramingError <= 1'b0;
            Overrun      <= 1'b0;
            ParityError  <= 1'b0;
            if (DataOutValid && DataOutReady) DataOutValid <= 1'b0;
            case (state)
                ST_IDLE: if (!rx) begin
                    state   <= ST_START;
                    counter <= '0;
                end
                ST_START: if (counter == SampleLast) begin
                    counter  <= '0;
                    bitIndex <= '0;
                    state    <= rx ? ST_IDLE : ST_DATA;
                end else counter <= counter + CounterWidth'(1);
                ST_DATA: if (counter == SymbolLast) begin
                    counter  <= '0;
                    shiftReg <= {rx, shiftReg[DATA_BITS-1:1]};
                    bitIndex <= bitIndex + BIT_INDEX_WIDTH'(1);
`ifdef UART_RX_PARITY_EN
                    if (bitIndex == LastBit) state <= ST_PARITY;
`else
                    if (bitIndex == LastBit) state <= ST_STOP;
`endif
                end else counter <= counter + CounterWidth'(1);
`ifdef UART_RX_PARITY_EN
                ST_PARITY: if (counter == SymbolLast) begin
                    counter <= '0;
                    state   <= ST_STOP;
                end else counter <= counter + CounterWidth'(1);
`endif
                // Return to IDLE at mid-stop-bit so a following start edge is not missed.
                ST_STOP: if (counter == SymbolLast) begin
                    counter     <= '0;
                    ParityError <= parityBad;
                    if (rx) begin
                        state <= ST_IDLE;
                        if (!parityBad) begin
                            if (!DataOutValid || DataOutReady) begin
                                DataOut      <= shiftReg;
                                DataOutValid <= 1'b1;
                            end else Overrun <= 1'b1;
                        end
                    end else begin
                        FramingError <= 1'b1;
                        state        <= ST_BREAK;
                    end
                end else counter <= counter + CounterWidth'(1);
                ST_BREAK: if (rx) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frames checked against a frame-level reference model.
module tb_uart_receiver;

    localparam int ClockFreq = 1_000_000;
    localparam int BaudRate  = 62_500;
    localparam int Sym       = ClockFreq / BaudRate;
    localparam int Samp      = Sym / 2;
`ifdef UART_RX_PARITY_EN
    localparam int Latency   = 2 + Samp + 10 * Sym + 1;
`else
    localparam int Latency   = 2 + Samp + 9 * Sym + 1;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       SIn = 1'b1;
    logic       DataOutReady = 1'b1;
    logic [7:0] DataOut;
    logic       DataOutValid, FramingError, Overrun, ParityError;

    uart_receiver #(.ClockFreq(ClockFreq), .BaudRate(BaudRate)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SIn         (SIn),
        .DataOut     (DataOut),
        .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady),
        .FramingError(FramingError),
        .Overrun     (Overrun),
        .ParityError (ParityError)
    );

    always #5 Clock = ~Clock;

    int cycle = 0;
    always @(posedge Clock) cycle <= cycle + 1;

    logic [7:0] rxBytes[$];
    int rxTimes[$];
    int feCount = 0, ovCount = 0, peCount = 0, validCycles = 0, pulseErr = 0, lastOvCycle = 0;
    logic prevValid = 0, prevReady = 0, prevFe = 0, prevOv = 0, prevPe = 0;

    // Observe at the falling edge: a byte is new when Valid rises or persists across a transfer.
    always @(negedge Clock) begin
        if (Reset) begin
            prevValid = 0; prevFe = 0; prevOv = 0; prevPe = 0;
        end else begin
            if (DataOutValid && (!prevValid || prevReady)) begin
                rxBytes.push_back(DataOut);
                rxTimes.push_back(cycle);
            end
            if (DataOutValid) validCycles++;
            if (FramingError) feCount++;
            if (Overrun) begin ovCount++; lastOvCycle = cycle; end
            if (ParityError) peCount++;
            if ((FramingError && prevFe) || (Overrun && prevOv) || (ParityError && prevPe)) pulseErr++;
            prevValid = DataOutValid; prevFe = FramingError; prevOv = Overrun; prevPe = ParityError;
        end
        prevReady = DataOutReady;
    end

    int testCount = 0, failCount = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge Clock);
        if (n > 0) #1;
    endtask

    task automatic sendFrame(logic [7:0] b, logic stopBit, logic parFlip, output int startCycle);
        startCycle = cycle;
        SIn = 1'b0;
        tick(Sym);
        for (int i = 0; i < 8; i++) begin
            SIn = b[i];
            tick(Sym);
        end
`ifdef UART_RX_PARITY_EN
        SIn = ^b ^ parFlip;
        tick(Sym);
`endif
        SIn = stopBit;
        tick(Sym);
        SIn = 1'b1;
    endtask

    function automatic logic inWindow(int got, int exp);
        return (got >= exp - 2) && (got <= exp + 2);
    endfunction

    int st, st2, b0, fe0, ov0, pe0, vc0;
    logic [7:0] expBytes[$];
    int expTimes[$];
    int expFe, expPe;

    initial begin
        #0.1;
        fork
            begin
                #5ms;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1);
            end
        join_none

        tick(3);
        check("rst_data", DataOut, 8'h00);
        check("rst_valid", DataOutValid, 1'b0);
        check("rst_fe", FramingError, 1'b0);
        check("rst_ov", Overrun, 1'b0);
        check("rst_pe", ParityError, 1'b0);
        Reset = 1'b0;
        tick(4);
        check("rel_valid", DataOutValid, 1'b0);

        b0 = rxBytes.size(); fe0 = feCount; ov0 = ovCount; pe0 = peCount; vc0 = validCycles;
        sendFrame(8'h7A, 1'b1, 1'b0, st);
        tick(4);
        check("f7a_count", rxBytes.size() - b0, 1);
        if (rxBytes.size() > b0) begin
            check("f7a_data", rxBytes[b0], 8'h7A);
            check("f7a_latency", inWindow(rxTimes[b0], st + Latency), 1'b1);
        end
        check("f7a_vcycles", validCycles - vc0, 1);
        check("f7a_errs", (feCount - fe0) + (ovCount - ov0) + (peCount - pe0), 0);

        DataOutReady = 1'b0;
        b0 = rxBytes.size(); ov0 = ovCount;
        sendFrame(8'h55, 1'b1, 1'b0, st);
        sendFrame(8'hA3, 1'b1, 1'b0, st2);
        tick(4);
        check("ovr_count", rxBytes.size() - b0, 1);
        check("ovr_pulses", ovCount - ov0, 1);
        check("ovr_time", inWindow(lastOvCycle, st2 + Latency), 1'b1);
        check("ovr_data", DataOut, 8'h55);
        check("ovr_valid", DataOutValid, 1'b1);
        DataOutReady = 1'b1;
        tick(1);
        check("ovr_drain", DataOutValid, 1'b0);
        check("ovr_nonew", rxBytes.size() - b0, 1);

        b0 = rxBytes.size(); fe0 = feCount;
        sendFrame(8'hC1, 1'b0, 1'b0, st);
        SIn = 1'b0;
        tick(200);
        check("brk_fe", feCount - fe0, 1);
        check("brk_nobyte", rxBytes.size() - b0, 0);
        check("brk_valid", DataOutValid, 1'b0);
        SIn = 1'b1;
        tick(Sym);
        sendFrame(8'h12, 1'b1, 1'b0, st);
        tick(4);
        check("brk_next", rxBytes.size() - b0, 1);
        if (rxBytes.size() > b0) check("brk_data", rxBytes[b0], 8'h12);
        check("brk_fe_total", feCount - fe0, 1);

        b0 = rxBytes.size(); fe0 = feCount; ov0 = ovCount; pe0 = peCount;
        SIn = 1'b0;
        tick(Samp / 2);
        SIn = 1'b1;
        tick(Samp + 5);
        check("gl_nobyte", rxBytes.size() - b0, 0);
        check("gl_errs", (feCount - fe0) + (ovCount - ov0) + (peCount - pe0), 0);
        sendFrame(8'h96, 1'b1, 1'b0, st);
        tick(4);
        check("gl_next", rxBytes.size() - b0, 1);
        if (rxBytes.size() > b0) check("gl_data", rxBytes[b0], 8'h96);

        b0 = rxBytes.size();
        SIn = 1'b0;
        tick(Sym);
        for (int i = 0; i < 4; i++) begin
            SIn = ($urandom_range(0, 1) == 1);
            tick(Sym);
        end
        Reset = 1'b1;
        SIn = 1'b1;
        tick(2);
        check("mid_rst_valid", DataOutValid, 1'b0);
        check("mid_rst_data", DataOut, 8'h00);
        Reset = 1'b0;
        tick(2 * Sym);
        sendFrame(8'h3C, 1'b1, 1'b0, st);
        tick(Sym);
        check("mid_count", rxBytes.size() - b0, 1);
        if (rxBytes.size() > b0) check("mid_data", rxBytes[b0], 8'h3C);

`ifdef UART_RX_PARITY_EN
        b0 = rxBytes.size(); pe0 = peCount;
        sendFrame(8'h7A, 1'b1, 1'b0, st);
        tick(4);
        check("par_ok", rxBytes.size() - b0, 1);
        sendFrame(8'h7A, 1'b1, 1'b1, st);
        tick(4);
        check("par_bad_pe", peCount - pe0, 1);
        check("par_bad_nobyte", rxBytes.size() - b0, 1);
`endif

        b0 = rxBytes.size(); fe0 = feCount; ov0 = ovCount; pe0 = peCount;
        expFe = 0; expPe = 0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic stopBit, parFlip;
            int gap;
            b = 8'($urandom);
            stopBit = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            parFlip = ($urandom_range(0, 5) == 0);
`else
            parFlip = 1'b0;
`endif
            sendFrame(b, stopBit, parFlip, st);
            if (stopBit && !parFlip) begin
                expBytes.push_back(b);
                expTimes.push_back(st + Latency);
            end
            if (!stopBit) expFe++;
            if (parFlip) expPe++;
            gap = $urandom_range(0, 12) + (stopBit ? 0 : 4);
            tick(gap);
        end
        tick(Sym);
        check("rnd_count", rxBytes.size() - b0, expBytes.size());
        for (int i = 0; i < expBytes.size(); i++)
            if (b0 + i < rxBytes.size()) begin
                check($sformatf("rnd_data%0d", i), rxBytes[b0 + i], expBytes[i]);
                check($sformatf("rnd_lat%0d", i), inWindow(rxTimes[b0 + i], expTimes[i]), 1'b1);
            end
        check("rnd_fe", feCount - fe0, expFe);
        check("rnd_pe", peCount - pe0, expPe);
        check("rnd_ov", ovCount - ov0, 0);
        check("pulse_width", pulseErr, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
